muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide controller for the execute stage; implements the RV32M operations on one shared shift/add-subtract datapath, one bit per cycle. Sits beside the ALU in execute and takes the forwarded operands. While an operation is in flight it holds the front of the pipeline with a stall request. It returns the result in the single cycle in which that stall is released.

## Interface
- `DATA_WIDTH`, 32 — operand and result width; the iteration count equals `DATA_WIDTH`.
- `clk`  input  1  — clock; all state changes on the rising edge.
- `rst_n`  input  1  — asynchronous, active-low reset.
- `Start_i`  input  1  — request; sampled only in IDLE.
- `Funct3_i`  input  3  — RV32M funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA_i`  input  DATA_WIDTH  — rs1 after forwarding.
- `SrcB_i`  input  DATA_WIDTH  — rs2 after forwarding.
- `Flush_i`  input  1  — branch-redirect kill; aborts any operation.
- `Busy_o`  output  1  — state is not IDLE.
- `Stall_o`  output  1  — stall request to fetch, decode and the execute pipeline register.
- `Done_o`  output  1  — one-cycle pulse; `Result_o` is valid in that cycle.
- `Result_o`  output  DATA_WIDTH  — result; 0 whenever `Done_o` = 0.

## Operation
- **States:** IDLE, RUN, FIX, DONE, encoded in 2 bits.
- **IDLE → RUN** when `Start_i` = 1 and `Flush_i` = 0:
  - Latch `Funct3_i`.
  - Latch the absolute values of the signed operands and both operand signs.
  - Load the iteration counter with `DATA_WIDTH`-1.
  - Clear the 2×`DATA_WIDTH` accumulator.
- **RUN:**
  - Multiply: shift-and-add, LSB first.
  - Divide: restoring shift-subtract, MSB first.
  - Decrement the counter each cycle. On the cycle the counter is 0, go to FIX.
- **FIX:**
  - Apply sign correction:
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the dividend's sign.
  - Select the result:
    - MUL: low half.
    - MULH/MULHSU/MULHU: high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register the result, then go to DONE.
- **DONE:** `Done_o` = 1 and `Result_o` = registered result for exactly one cycle, then IDLE.
- **Special cases:** the selected result is overridden in FIX.
  - Divide by zero: quotient = all ones; remainder = `SrcA`.
  - Signed overflow (DIV/REM with `SrcA` = 0x80000000 and `SrcB` = 0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- **Signedness:**
  - MULHSU treats A as signed and B as unsigned.
  - MULHU, DIVU and REMU treat both operands as unsigned.
- **`Stall_o`** = (IDLE & `Start_i`) | RUN | FIX. It is low in DONE so the pipeline advances and captures `Result_o`.
- **Input rules:**
  - `Start_i` in RUN, FIX or DONE is ignored.
  - Operands are not re-sampled after the IDLE edge.
- **`Flush_i`** = 1 in any state forces IDLE on the next edge:
  - `Done_o` is suppressed.
  - `Stall_o` goes low in the same cycle, combinationally.
  - `Flush_i` has priority over `Start_i`.

## Timing
- **Reset:**
  - State = IDLE; counter, accumulator, latched operands and result register = 0.
  - `Busy_o`, `Stall_o`, `Done_o` = 0; `Result_o` = 0.
  - Reset asserted mid-operation aborts the operation with no `Done_o`.
- **Latency:** with `Start_i` high in cycle k:
  - RUN spans cycles k+1 … k+`DATA_WIDTH`.
  - FIX is cycle k+`DATA_WIDTH`+1.
  - `Done_o` is high in cycle k+`DATA_WIDTH`+2 (k+34 at default width).
- **Throughput:**
  - A new `Start_i` is accepted at the earliest in the cycle after DONE.
  - Back-to-back operations are therefore spaced `DATA_WIDTH`+3 cycles apart.
- **Outputs:** `Busy_o`, `Done_o` and `Result_o` are registered or state-decoded. Only `Stall_o` depends combinationally on `Start_i`.

## Configuration
- **`MULDIV_EARLY_OUT_EN` defined:**
  - Divide by zero and signed overflow skip RUN: IDLE → FIX directly.
  - `Done_o` is then high in cycle k+2.
  - Multiply by zero (either operand 0) also takes this path, with result 0.
- **Not defined:** every operation takes the full `DATA_WIDTH`+2 latency, with results overridden in FIX as described under Operation.

## Test plan
- **Signed multiply:** MUL with A=0xFFFFFFFD (-3), B=7 at cycle k.
  - `Done_o` only at k+34, `Result_o` = 0xFFFFFFEB.
  - `Stall_o` high in cycles k … k+33.
- **High-half multiply:** MULH/MULHSU/MULHU with A=0x80000000, B=0xFFFFFFFF.
  - Results are 0x00000000, 0x80000000 and 0x7FFFFFFF respectively.
- **Signed divide:** DIV with A=-7, B=2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- **Corner cases:**
  - DIVU x/0 with x=5 → 0xFFFFFFFF; REM x/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
  - With `MULDIV_EARLY_OUT_EN`, `Done_o` at k+2; without it, at k+34.
- **Flush mid-operation:** `Flush_i` at k+10 → IDLE at k+11, no `Done_o`. A new `Start_i` at k+11 completes normally at k+45.
- **Reset mid-operation:** `rst_n` low at k+20.
  - All outputs go to 0 immediately.
  - After release, a `Start_i` in that same cycle is accepted.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Iterative RV32M multiply/divide controller for the execute stage. One shared
// shift/add-subtract datapath retires one operand bit per clock. While an
// operation is in flight the front of the pipeline is held with Stall_o; the
// result is presented (Done_o pulse) in the single cycle the stall drops.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   Start_i               request, sampled only in IDLE
//   Funct3_i[2:0]         RV32M funct3 (MUL..REMU)
//   SrcA_i, SrcB_i        forwarded rs1 / rs2
//   Flush_i               branch-redirect kill, aborts any operation
//   Busy_o                state is not IDLE
//   Stall_o               stall request to fetch/decode/execute register
//   Done_o                one-cycle result-valid pulse
//   Result_o              result, zero whenever Done_o is low
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let divide-by-zero, signed
// overflow and multiply-by-zero skip RUN and go straight from IDLE to FIX.

module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Start_i,
    input  logic [2:0]            Funct3_i,
    input  logic [DATA_WIDTH-1:0] SrcA_i,
    input  logic [DATA_WIDTH-1:0] SrcB_i,
    input  logic                  Flush_i,
    output logic                  Busy_o,
    output logic                  Stall_o,
    output logic                  Done_o,
    output logic [DATA_WIDTH-1:0] Result_o
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_next;
    logic [2:0]      funct3_q;
    logic [W-1:0]    abs_a, abs_b;
    logic            sign_a, sign_b;
    logic [CW-1:0]   count;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    result_q;

    // Operand signedness per funct3: only MULHU/DIVU/REMU treat A as unsigned,
    // and MULHSU additionally treats B as unsigned.
    logic            a_signed_in, b_signed_in, sign_a_in, sign_b_in;
    logic [W-1:0]    abs_a_in, abs_b_in;
    logic            accept, early_in;

    always_comb begin
        a_signed_in = ~Funct3_i[0] | (Funct3_i == 3'b001);
        b_signed_in = (Funct3_i[2] & ~Funct3_i[0]) | (Funct3_i[2:1] == 2'b00);
        sign_a_in   = a_signed_in & SrcA_i[W-1];
        sign_b_in   = b_signed_in & SrcB_i[W-1];
        abs_a_in    = sign_a_in ? -SrcA_i : SrcA_i;
        abs_b_in    = sign_b_in ? -SrcB_i : SrcB_i;
        accept      = (state == IDLE) & Start_i & ~Flush_i;
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Operations whose answer is fixed by the operands alone bypass RUN; the
    // FIX overrides (and the cleared accumulator for multiply) supply the result.
    logic ovf_in;
    always_comb begin
        ovf_in   = Funct3_i[2] & ~Funct3_i[0] & (SrcA_i == MIN_NEG) & (&SrcB_i);
        early_in = Funct3_i[2] ? ((SrcB_i == '0) | ovf_in)
                               : ((SrcA_i == '0) | (SrcB_i == '0));
    end
`else
    assign early_in = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; a flush overrides every transition, including a start.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (Start_i) state_next = early_in ? FIX : RUN;
            RUN:  if (count == '0) state_next = FIX;
            FIX:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (Flush_i) state_next = IDLE;
    end

    // One iteration of the shared datapath. Multiply adds |A| into the upper
    // half for each set bit of |B| (LSB first) and shifts right. Divide shifts
    // the next dividend bit (MSB first) into the partial remainder in the upper
    // half and builds the quotient in the lower half. The trial subtraction
    // carries two extra bits because the shifted remainder can exceed W bits.
    logic [CW-1:0]  idx_mul;
    logic [W:0]     mul_sum;
    logic [W+1:0]   trial;
    logic [2*W-1:0] acc_step;

    always_comb begin
        idx_mul  = CW'(W - 1) - count;
        mul_sum  = {1'b0, acc[2*W-1:W]} + (abs_b[idx_mul] ? {1'b0, abs_a} : '0);
        trial    = {1'b0, acc[2*W-1:W], abs_a[count]} - {2'b00, abs_b};
        acc_step = '0;
        if (!funct3_q[2]) begin
            acc_step = {mul_sum, acc[W-1:1]};
        end else if (!trial[W+1]) begin
            acc_step = {trial[W-1:0], acc[W-2:0], 1'b1};
        end else begin
            acc_step = {acc[2*W-2:W], abs_a[count], acc[W-2:0], 1'b0};
        end
    end

    // Sign correction and result selection. The original dividend for the
    // divide-by-zero remainder is rebuilt from its magnitude and sign.
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, orig_a, fix_result;
    logic           b_zero, ovf;

    always_comb begin
        prod   = (sign_a ^ sign_b) ? -acc : acc;
        quo    = (sign_a ^ sign_b) ? -acc[W-1:0] : acc[W-1:0];
        rem    = sign_a ? -acc[2*W-1:W] : acc[2*W-1:W];
        orig_a = sign_a ? -abs_a : abs_a;
        b_zero = (abs_b == '0);
        ovf    = sign_a & sign_b & (abs_a == MIN_NEG) & (abs_b == W'(1));
        fix_result = '0;
        case (funct3_q)
            3'b000:                 fix_result = prod[W-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod[2*W-1:W];
            3'b100, 3'b101:         fix_result = b_zero ? '1 : (ovf ? MIN_NEG : quo);
            default:                fix_result = b_zero ? orig_a : (ovf ? '0 : rem);
        endcase
    end

    // Datapath registers: operands latched on acceptance, iterate in RUN,
    // capture the corrected result in FIX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            funct3_q <= '0;
            abs_a    <= '0;
            abs_b    <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            count    <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    funct3_q <= Funct3_i;
                    abs_a    <= abs_a_in;
                    abs_b    <= abs_b_in;
                    sign_a   <= sign_a_in;
                    sign_b   <= sign_b_in;
                    count    <= CW'(W - 1);
                    acc      <= '0;
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count - CW'(1);
                end
                FIX: result_q <= fix_result;
                default: ;
            endcase
        end
    end

    // Stall drops combinationally on a flush so the redirect is not held off.
    always_comb begin
        Busy_o   = (state != IDLE);
        Stall_o  = ~Flush_i & (((state == IDLE) & Start_i) | (state == RUN) | (state == FIX));
        Done_o   = (state == DONE) & ~Flush_i;
        Result_o = Done_o ? result_q : '0;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer
// Directed self-checking bench for muldiv_sequencer: signed/unsigned multiply
// and divide results, latency and stall window, corner cases, flush and reset
// mid-operation. Build with +define+MULDIV_EARLY_OUT_EN to match an RTL built
// with the early-out feature.

module tb_muldiv_sequencer;

    localparam int W   = 32;
    localparam int LAT = W + 2;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 2;
`else
    localparam int SPECIAL_LAT = LAT;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Start;
    logic [2:0]    Funct3;
    logic [W-1:0]  SrcA;
    logic [W-1:0]  SrcB;
    logic          Flush;
    logic          Busy;
    logic          Stall;
    logic          Done;
    logic [W-1:0]  Result;

    int checks = 0;
    int errors = 0;

    muldiv_sequencer #(.DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start_i  (Start),
        .Funct3_i (Funct3),
        .SrcA_i   (SrcA),
        .SrcB_i   (SrcB),
        .Flush_i  (Flush),
        .Busy_o   (Busy),
        .Stall_o  (Stall),
        .Done_o   (Done),
        .Result_o (Result)
    );

    always #5 clk = ~clk;

    // Safety net so the bench can never hang.
    initial begin
        #1000000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic check_output(input string tag, input logic [W-1:0] observed,
                                input logic [W-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] f3, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
        Start  = 1'b1;
        Funct3 = f3;
        SrcA   = a;
        SrcB   = b;
    endtask

    // Called in the start cycle k (after the rising edge, before the falling
    // edge). Follows the operation to its Done cycle and one cycle beyond.
    // With poke set, a spurious Start is raised mid-operation to show it is ignored.
    task automatic track_op(input string tag, input logic [W-1:0] exp_res,
                            input int exp_lat, input bit poke);
        bit early_done = 1'b0;
        bit stall_gap  = 1'b0;
        @(negedge clk);
        check_output({tag, "_stall_start"}, {31'b0, Stall}, 32'd1);
        @(posedge clk);
        #1;
        Start  = 1'b0;
        SrcA   = 32'hA5A5A5A5;
        SrcB   = 32'h5A5A5A5A;
        Funct3 = Funct3 ^ 3'b100;
        for (int c = 1; c < exp_lat; c++) begin
            @(negedge clk);
            if (Done !== 1'b0) early_done = 1'b1;
            if (Stall !== 1'b1) stall_gap = 1'b1;
            if (poke && c == 3) Start = 1'b1;
            if (poke && c == 4) Start = 1'b0;
        end
        @(negedge clk);
        check_output({tag, "_no_early_done"}, {31'b0, early_done}, 32'd0);
        check_output({tag, "_stall_window"}, {31'b0, stall_gap}, 32'd0);
        check_output({tag, "_done"}, {31'b0, Done}, 32'd1);
        check_output({tag, "_result"}, Result, exp_res);
        check_output({tag, "_stall_done"}, {31'b0, Stall}, 32'd0);
        @(negedge clk);
        check_output({tag, "_done_after"}, {31'b0, Done}, 32'd0);
        check_output({tag, "_result_after"}, Result, 32'd0);
        check_output({tag, "_busy_after"}, {31'b0, Busy}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_res,
                          input int exp_lat, input bit poke);
        @(posedge clk);
        #1;
        apply_stimulus(f3, a, b);
        track_op(tag, exp_res, exp_lat, poke);
    endtask

    initial begin
        bit flushed_done;
        rst_n  = 1'b0;
        Start  = 1'b0;
        Flush  = 1'b0;
        Funct3 = 3'b000;
        SrcA   = '0;
        SrcB   = '0;
        #2;
        check_output("reset_busy", {31'b0, Busy}, 32'd0);
        check_output("reset_stall", {31'b0, Stall}, 32'd0);
        check_output("reset_done", {31'b0, Done}, 32'd0);
        check_output("reset_result", Result, 32'd0);
        #10;
        rst_n = 1'b1;

        // Multiply
        run_op("mul_neg",    3'b000, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, LAT, 1'b1);
        run_op("mulh",       3'b001, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT, 1'b0);
        run_op("mulhsu",     3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT, 1'b0);
        run_op("mulhu",      3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, LAT, 1'b0);
        run_op("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT, 1'b0);
        run_op("mul_max",    3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, LAT, 1'b0);
        run_op("mul_zero",   3'b000, 32'd0,        32'd1234,     32'h00000000, SPECIAL_LAT, 1'b0);

        // Divide
        run_op("div_neg",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT, 1'b0);
        run_op("rem_neg",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT, 1'b0);
        run_op("div_negb",   3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, LAT, 1'b0);
        run_op("rem_negb",   3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, LAT, 1'b0);
        run_op("divu",       3'b101, 32'd100,      32'd7,        32'd14,       LAT, 1'b0);
        run_op("remu",       3'b111, 32'd100,      32'd7,        32'd2,        LAT, 1'b0);
        run_op("divu_big",   3'b101, 32'hFFFFFFFF, 32'h80000001, 32'd1,        LAT, 1'b0);
        run_op("remu_big",   3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, LAT, 1'b0);

        // Corner cases
        run_op("divu_zero",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, SPECIAL_LAT, 1'b0);
        run_op("rem_zero",   3'b110, 32'd5,        32'd0,        32'd5,        SPECIAL_LAT, 1'b0);
        run_op("rem_zero_n", 3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, SPECIAL_LAT, 1'b0);
        run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPECIAL_LAT, 1'b0);
        run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, SPECIAL_LAT, 1'b0);

        // Flush at k+10, new start at k+11 completes at k+45
        @(posedge clk);
        #1;
        apply_stimulus(3'b101, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        Start = 1'b0;
        flushed_done = 1'b0;
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (Done !== 1'b0) flushed_done = 1'b1;
            @(posedge clk);
            #1;
        end
        Flush = 1'b1;
        #1;
        check_output("flush_stall", {31'b0, Stall}, 32'd0);
        check_output("flush_busy", {31'b0, Busy}, 32'd1);
        check_output("flush_done", {31'b0, flushed_done | Done}, 32'd0);
        @(posedge clk);
        #1;
        Flush = 1'b0;
        check_output("flush_idle", {31'b0, Busy}, 32'd0);
        apply_stimulus(3'b100, 32'hFFFFFFF9, 32'd2);
        track_op("after_flush", 32'hFFFFFFFD, LAT, 1'b0);

        // Reset at k+20, start accepted in the release cycle
        @(posedge clk);
        #1;
        apply_stimulus(3'b111, 32'd100, 32'd7);
        @(posedge clk);
        #1;
        Start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk);
            #1;
        end
        check_output("pre_reset_busy", {31'b0, Busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_output("midrst_busy", {31'b0, Busy}, 32'd0);
        check_output("midrst_stall", {31'b0, Stall}, 32'd0);
        check_output("midrst_done", {31'b0, Done}, 32'd0);
        check_output("midrst_result", Result, 32'd0);
        #1;
        rst_n = 1'b1;
        apply_stimulus(3'b000, 32'd6, 32'd7);
        track_op("after_reset", 32'd42, LAT, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
